// File: rtl/wb_intercon_wdt_if.sv
// Wishbone bus bundle between one master, the interconnect and its N slaves.
// The slave modport is the interconnect's view; master is the surrounding environment.
interface wb_intercon_wdt_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_SLAVES = 4
);
  logic [31:0]                      wbm_adr_i;
  logic [DATA_WIDTH-1:0]            wbm_dat_i;
  logic [DATA_WIDTH-1:0]            wbm_dat_o;
  logic [DATA_WIDTH/8-1:0]          wbm_sel_i;
  logic                             wbm_we_i;
  logic                             wbm_cyc_i;
  logic                             wbm_stb_i;
  logic                             wbm_ack_o;
  logic                             wbm_err_o;
  logic [31:0]                      wbs_adr_o;
  logic [DATA_WIDTH-1:0]            wbs_dat_o;
  logic [DATA_WIDTH/8-1:0]          wbs_sel_o;
  logic                             wbs_we_o;
  logic [NUM_SLAVES-1:0]            wbs_cyc_o;
  logic [NUM_SLAVES-1:0]            wbs_stb_o;
  logic [NUM_SLAVES*DATA_WIDTH-1:0] wbs_dat_i;
  logic [NUM_SLAVES-1:0]            wbs_ack_i;

  modport slave (
    input  wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    input  wbs_dat_i, wbs_ack_i,
    output wbm_dat_o, wbm_ack_o, wbm_err_o,
    output wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o
  );

  modport master (
    output wbm_adr_i, wbm_dat_i, wbm_sel_i, wbm_we_i, wbm_cyc_i, wbm_stb_i,
    output wbs_dat_i, wbs_ack_i,
    input  wbm_dat_o, wbm_ack_o, wbm_err_o,
    input  wbs_adr_o, wbs_dat_o, wbs_sel_o, wbs_we_o, wbs_cyc_o, wbs_stb_o
  );
endinterface

// File: rtl/wb_intercon_wdt.sv
// Single-master, N-slave Wishbone interconnect with registered address decode,
// error termination for unmapped/hung accesses and a sticky fault register.
module wb_intercon_wdt #(
  parameter int                        DATA_WIDTH  = 16,
  parameter int                        NUM_SLAVES  = 4,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_ADDRS = '0,
  parameter logic [NUM_SLAVES*32-1:0]  SLAVE_MASKS = '0,
  parameter int                        TIMEOUT     = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  wb_intercon_wdt_if.slave  bus,
  output logic              fault_o,
  output logic [31:0]       fault_adr_o,
  output logic              fault_tmo_o,
  input  logic              fault_clr_i
);

  localparam int            CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, DECODE, ACTIVE, ERR} state_t;

  state_t                state;
  state_t                state_nx;
  logic [31:0]           adr_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [NUM_SLAVES-1:0] match_sel;
  logic [CW-1:0]         cnt;
  logic                  req;
  logic                  sel_ack;
  logic                  fault_ev;
  logic                  fault_tmo_ev;

  assign req     = bus.wbm_cyc_i & bus.wbm_stb_i;
  assign sel_ack = |(bus.wbs_ack_i & sel_q);

  assign bus.wbs_adr_o = bus.wbm_adr_i;
  assign bus.wbs_dat_o = bus.wbm_dat_i;
  assign bus.wbs_sel_o = bus.wbm_sel_i;
  assign bus.wbs_we_o  = bus.wbm_we_i;

  // Scanning downwards lets the lowest-index match overwrite higher ones on overlap.
  always_comb begin
    match_sel = '0;
    for (int k = NUM_SLAVES - 1; k >= 0; k--) begin
      if ((adr_q & SLAVE_MASKS[32*k +: 32]) ==
          (SLAVE_ADDRS[32*k +: 32] & SLAVE_MASKS[32*k +: 32]))
        match_sel = NUM_SLAVES'(1) << k;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    bus.wbm_ack_o = 1'b0;
    bus.wbm_err_o = 1'b0;
    bus.wbs_cyc_o = '0;
    bus.wbs_stb_o = '0;
    fault_ev      = 1'b0;
    fault_tmo_ev  = 1'b0;
    case (state)
      IDLE: begin
        if (req) state_nx = DECODE;
      end
      DECODE: begin
        if (!req) begin
          state_nx = IDLE;
        end else if (match_sel == '0) begin
          state_nx = ERR;
          fault_ev = 1'b1;
        end else begin
          state_nx = ACTIVE;
        end
      end
      ACTIVE: begin
        bus.wbs_cyc_o = sel_q;
        bus.wbs_stb_o = sel_q;
        bus.wbm_ack_o = sel_ack & req;
        // A slave ack in the final allowed cycle still beats the watchdog.
        if (!req || sel_ack) begin
          state_nx = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nx     = ERR;
          fault_ev     = 1'b1;
          fault_tmo_ev = 1'b1;
        end
      end
      ERR: begin
        bus.wbm_err_o = 1'b1;
        state_nx      = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      adr_q <= '0;
      sel_q <= '0;
      cnt   <= '0;
    end else begin
      if (state == IDLE && req) adr_q <= bus.wbm_adr_i;
      if (state == DECODE) begin
        sel_q <= match_sel;
        cnt   <= '0;
      end else if (state == ACTIVE && cnt != {CW{1'b1}}) begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_comb begin
    bus.wbm_dat_o = '0;
    if (state == ACTIVE) begin
      for (int k = 0; k < NUM_SLAVES; k++) begin
        if (sel_q[k]) bus.wbm_dat_o = bus.wbs_dat_i[DATA_WIDTH*k +: DATA_WIDTH];
      end
    end
  end

  // A fault coinciding with a clear request wins, so no fault is ever lost.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fault_o     <= 1'b0;
      fault_adr_o <= '0;
      fault_tmo_o <= 1'b0;
    end else if (fault_ev && (!fault_o || fault_clr_i)) begin
      fault_o     <= 1'b1;
      fault_adr_o <= adr_q;
      fault_tmo_o <= fault_tmo_ev;
    end else if (fault_clr_i) begin
      fault_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_intercon_wdt.sv
// Directed bench for wb_intercon_wdt: a transaction-level timeline model drives
// per-cycle expectations that a negedge compare process checks against the DUT.
module tb_wb_intercon_wdt;

  localparam int DW  = 16;
  localparam int NS  = 4;
  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        fault_o;
  logic [31:0] fault_adr_o;
  logic        fault_tmo_o;
  logic        fault_clr_i;

  wb_intercon_wdt_if #(.DATA_WIDTH(DW), .NUM_SLAVES(NS)) bus ();

  wb_intercon_wdt #(
    .DATA_WIDTH (DW),
    .NUM_SLAVES (NS),
    .SLAVE_ADDRS({32'hF0000000, 32'hF0000004, 32'hF0000000, 32'h00001000}),
    .SLAVE_MASKS({32'hF0000000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hFFFFF000}),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .bus        (bus),
    .fault_o    (fault_o),
    .fault_adr_o(fault_adr_o),
    .fault_tmo_o(fault_tmo_o),
    .fault_clr_i(fault_clr_i)
  );

  always #5 clk = ~clk;

  logic [31:0] base_tab [NS] = '{32'h00001000, 32'hF0000000, 32'hF0000004, 32'hF0000000};
  logic [31:0] mask_tab [NS] = '{32'hFFFFF000, 32'hFFFFFFFC, 32'hFFFFFFFC, 32'hF0000000};
  logic [15:0] data_tab [NS] = '{16'hBEEF, 16'h1111, 16'h2222, 16'h3333};
  int          slave_lat [NS] = '{1, 2, 0, 3};

  // Slave responders: ack after slave_lat edges of strobe; latency 0 never acks.
  logic [NS-1:0] s_ack = '0;
  int            s_wait [NS] = '{default: 0};

  assign bus.wbs_dat_i = {data_tab[3], data_tab[2], data_tab[1], data_tab[0]};
  assign bus.wbs_ack_i = s_ack;

  always @(posedge clk) begin
    for (int k = 0; k < NS; k++) begin
      if (bus.wbs_stb_o[k] && !s_ack[k] && slave_lat[k] != 0) begin
        if (s_wait[k] + 1 == slave_lat[k]) begin
          s_ack[k]  <= 1'b1;
          s_wait[k] <= 0;
        end else begin
          s_wait[k] <= s_wait[k] + 1;
        end
      end else begin
        s_ack[k] <= 1'b0;
        if (!bus.wbs_stb_o[k]) s_wait[k] <= 0;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  bit          chk_en = 1'b0;
  logic [NS-1:0] exp_stb;
  logic        exp_ack, exp_err, exp_we;
  logic [15:0] exp_dat, exp_wdat;
  logic [31:0] exp_adr;
  logic        m_fault, m_tmo;
  logic [31:0] m_adr;

  int            obs_ack_cycle, obs_ack_cnt, obs_err_cnt;
  int            obs_stb_cnt [NS];
  logic [NS-1:0] obs_stb_or;
  logic [15:0]   obs_dat;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h t=%0t", name, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("wbs_stb_o", 32'(bus.wbs_stb_o), 32'(exp_stb));
      checkOutput("wbs_cyc_o", 32'(bus.wbs_cyc_o), 32'(exp_stb));
      checkOutput("wbm_ack_o", 32'(bus.wbm_ack_o), 32'(exp_ack));
      checkOutput("wbm_err_o", 32'(bus.wbm_err_o), 32'(exp_err));
      checkOutput("wbm_dat_o", 32'(bus.wbm_dat_o), 32'(exp_dat));
      checkOutput("wbs_adr_o", bus.wbs_adr_o, exp_adr);
      checkOutput("wbs_dat_o", 32'(bus.wbs_dat_o), 32'(exp_wdat));
      checkOutput("wbs_we_o", 32'(bus.wbs_we_o), 32'(exp_we));
      checkOutput("wbs_sel_o", 32'(bus.wbs_sel_o), 32'h3);
      checkOutput("fault_o", 32'(fault_o), 32'(m_fault));
      checkOutput("fault_adr_o", fault_adr_o, m_adr);
      checkOutput("fault_tmo_o", 32'(fault_tmo_o), 32'(m_tmo));
    end
  end

  function automatic int decode(input logic [31:0] adr);
    for (int k = 0; k < NS; k++)
      if ((adr & mask_tab[k]) == (base_tab[k] & mask_tab[k])) return k;
    return -1;
  endfunction

  // Fault register rules applied at one clock edge.
  task automatic stepModel(input bit ev, input bit tmo, input bit clr, input bit rst,
                           input logic [31:0] adr);
    if (rst) begin
      m_fault = 1'b0; m_adr = '0; m_tmo = 1'b0;
    end else if (ev && (!m_fault || clr)) begin
      m_fault = 1'b1; m_adr = adr; m_tmo = tmo;
    end else if (clr) begin
      m_fault = 1'b0;
    end
  endtask

  task automatic driveMaster(input logic [31:0] adr, input logic we, input bit act);
    bus.wbm_adr_i = adr;
    bus.wbm_dat_i = adr[15:0] ^ 16'h5A5A;
    bus.wbm_sel_i = 2'b11;
    bus.wbm_we_i  = we;
    bus.wbm_cyc_i = act;
    bus.wbm_stb_i = act;
    exp_adr  = adr;
    exp_wdat = adr[15:0] ^ 16'h5A5A;
    exp_we   = we;
  endtask

  task automatic setIdleExp();
    exp_stb = '0; exp_ack = 1'b0; exp_err = 1'b0; exp_dat = '0;
  endtask

  task automatic observe(input int c);
    if (bus.wbm_ack_o) begin
      obs_ack_cnt++; obs_ack_cycle = c; obs_dat = bus.wbm_dat_o;
    end
    if (bus.wbm_err_o) obs_err_cnt++;
    obs_stb_or |= bus.wbs_stb_o;
    for (int k = 0; k < NS; k++) if (bus.wbs_stb_o[k]) obs_stb_cnt[k]++;
  endtask

  task automatic idleCycles(input int n, input bit clr);
    bit prev_clr = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c > 0) stepModel(1'b0, 1'b0, prev_clr, 1'b0, '0);
      driveMaster(exp_adr, 1'b0, 1'b0);
      fault_clr_i = clr && (c == 0);
      setIdleExp();
      prev_clr = fault_clr_i;
      @(posedge clk); #1;
    end
    stepModel(1'b0, 1'b0, prev_clr, 1'b0, '0);
    fault_clr_i = 1'b0;
  endtask

  // One master access. Cycle 0 raises stb, decode occupies cycle 1, the slave
  // sees stb from cycle 2; abort_cycle>0 ends it early (by stb drop or by reset).
  task automatic applyStimulus(input logic [31:0] adr, input logic we, input int abort_cycle,
                               input bit abort_rst, input int clr_cycle);
    int tgt, ack_c, err_c, last_act, ncyc;
    bit prev_clr, prev_rst, act;
    logic [NS-1:0] onehot;
    tgt = decode(adr);
    ack_c = -1; err_c = -1; last_act = -1;
    onehot = (tgt >= 0) ? (NS'(1) << tgt) : '0;
    if (tgt < 0) begin
      err_c = 2;
      ncyc  = 3;
    end else if (slave_lat[tgt] != 0 && slave_lat[tgt] <= TMO - 1) begin
      ack_c = 2 + slave_lat[tgt]; last_act = ack_c; ncyc = ack_c + 1;
    end else begin
      last_act = 2 + TMO - 1; err_c = 2 + TMO; ncyc = err_c + 1;
    end
    if (abort_cycle > 0) begin
      if (last_act > abort_cycle) last_act = abort_cycle;
      ack_c = -1; err_c = -1; ncyc = abort_cycle + 1;
    end
    obs_ack_cycle = -1; obs_ack_cnt = 0; obs_err_cnt = 0; obs_stb_or = '0; obs_dat = '0;
    for (int k = 0; k < NS; k++) obs_stb_cnt[k] = 0;
    prev_clr = 1'b0; prev_rst = 1'b0;
    for (int c = 0; c <= ncyc; c++) begin
      if (c > 0) stepModel(c == err_c, tgt >= 0, prev_clr, prev_rst, adr);
      act = (abort_cycle > 0 && !abort_rst) ? (c < abort_cycle) : (c < ncyc);
      driveMaster(adr, we, act);
      rst_i       = abort_rst && (c == abort_cycle);
      fault_clr_i = (c == clr_cycle);
      exp_stb = (tgt >= 0 && c >= 2 && c <= last_act) ? onehot : '0;
      exp_dat = (tgt >= 0 && c >= 2 && c <= last_act) ? data_tab[tgt] : '0;
      exp_ack = (c == ack_c);
      exp_err = (c == err_c);
      prev_clr = fault_clr_i;
      prev_rst = rst_i;
      @(negedge clk);
      observe(c);
      @(posedge clk); #1;
    end
    stepModel(1'b0, 1'b0, prev_clr, prev_rst, adr);
    rst_i = 1'b0;
    fault_clr_i = 1'b0;
    setIdleExp();
  endtask

  initial begin
    rst_i = 1'b1;
    fault_clr_i = 1'b0;
    driveMaster('0, 1'b0, 1'b0);
    setIdleExp();
    m_fault = 1'b0; m_adr = '0; m_tmo = 1'b0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    checkOutput("reset_stb", 32'(bus.wbs_stb_o), 32'h0);
    checkOutput("reset_fault", 32'(fault_o), 32'h0);

    applyStimulus(32'h00001234, 1'b0, 0, 1'b0, -1);
    checkOutput("rom_ack_cycle", obs_ack_cycle, 3);
    checkOutput("rom_data", 32'(obs_dat), 32'h0000BEEF);
    checkOutput("rom_stb", 32'(obs_stb_or), 32'h1);
    applyStimulus(32'h00001000, 1'b0, 0, 1'b0, -1);
    checkOutput("b2b_ack_cycle", obs_ack_cycle, 3);

    applyStimulus(32'h80000000, 1'b1, 0, 1'b0, -1);
    checkOutput("unmapped_stb", 32'(obs_stb_or), 32'h0);
    checkOutput("unmapped_err_cnt", obs_err_cnt, 1);
    checkOutput("unmapped_fault", 32'(fault_o), 32'h1);
    checkOutput("unmapped_fault_adr", fault_adr_o, 32'h80000000);
    checkOutput("unmapped_fault_tmo", 32'(fault_tmo_o), 32'h0);
    idleCycles(2, 1'b1);
    checkOutput("clear_1", 32'(fault_o), 32'h0);

    applyStimulus(32'hF0000004, 1'b1, 0, 1'b0, -1);
    checkOutput("tmo_stb_cycles", obs_stb_cnt[2], 8);
    checkOutput("tmo_err_cnt", obs_err_cnt, 1);
    checkOutput("tmo_fault_tmo", 32'(fault_tmo_o), 32'h1);
    checkOutput("tmo_fault_adr", fault_adr_o, 32'hF0000004);
    applyStimulus(32'h80000010, 1'b0, 0, 1'b0, -1);
    checkOutput("second_fault_adr", fault_adr_o, 32'hF0000004);
    checkOutput("second_fault_tmo", 32'(fault_tmo_o), 32'h1);
    idleCycles(2, 1'b1);
    checkOutput("clear_2", 32'(fault_o), 32'h0);

    slave_lat[3] = 7;
    applyStimulus(32'hF1000000, 1'b0, 0, 1'b0, -1);
    checkOutput("race_ack_cycle", obs_ack_cycle, 9);
    checkOutput("race_err_cnt", obs_err_cnt, 0);
    checkOutput("race_fault", 32'(fault_o), 32'h0);
    checkOutput("race_stb_cycles", obs_stb_cnt[3], 8);
    slave_lat[3] = 3;

    applyStimulus(32'hF0000000, 1'b0, 0, 1'b0, -1);
    checkOutput("overlap_stb", 32'(obs_stb_or), 32'h2);
    checkOutput("overlap_ack_cycle", obs_ack_cycle, 4);
    checkOutput("overlap_data", 32'(obs_dat), 32'h00001111);

    applyStimulus(32'hF0000004, 1'b0, 4, 1'b0, -1);
    checkOutput("abort_ack_cnt", obs_ack_cnt, 0);
    checkOutput("abort_err_cnt", obs_err_cnt, 0);
    checkOutput("abort_stb_cycles", obs_stb_cnt[2], 3);
    checkOutput("abort_fault", 32'(fault_o), 32'h0);
    applyStimulus(32'h00001234, 1'b0, 1, 1'b0, -1);
    checkOutput("abort_decode_stb", 32'(obs_stb_or), 32'h0);

    applyStimulus(32'hF2000008, 1'b1, 0, 1'b0, -1);
    checkOutput("write_s3_ack_cycle", obs_ack_cycle, 5);

    applyStimulus(32'h80000000, 1'b1, 0, 1'b0, -1);
    applyStimulus(32'h80000020, 1'b0, 0, 1'b0, 1);
    checkOutput("clr_race_fault", 32'(fault_o), 32'h1);
    checkOutput("clr_race_adr", fault_adr_o, 32'h80000020);

    applyStimulus(32'hF0000004, 1'b0, 3, 1'b1, -1);
    checkOutput("rst_mid_fault", 32'(fault_o), 32'h0);
    checkOutput("rst_mid_stb", 32'(bus.wbs_stb_o), 32'h0);
    checkOutput("rst_mid_fault_adr", fault_adr_o, 32'h0);
    idleCycles(2, 1'b0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_intercon_wdt.md
Name: wb_intercon_wdt

Overview:
Parametrised single-master, N-slave Wishbone interconnect with an integrated bus watchdog. It is the successor to the fixed 4-slave decoder plus separate watchdog in the Marin SoC. It sits between the moxielite_wb core and the ROM/RAM/display/UART slaves. It adds registered address decode and WB error termination for unmapped addresses and hung slaves. It also provides a sticky fault register.

Parameters:
DATA_WIDTH, 16, data bus width in bits; multiple of 8.
NUM_SLAVES, 4, number of slave ports, 1..16.
SLAVE_ADDRS, 0, NUM_SLAVES*32-bit packed vector; slave k base address at bits [32k+31:32k].
SLAVE_MASKS, 0, NUM_SLAVES*32-bit packed vector; slave k matches when (adr & mask_k) == (addr_k & mask_k).
TIMEOUT, 255, cycles a selected slave may hold off ack before an error is issued; 1..65535.

Ports:
clk_i  in  1  system clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
wbm_adr_i  in  32  master address
wbm_dat_i  in  DATA_WIDTH  master write data
wbm_dat_o  out  DATA_WIDTH  read data to master
wbm_sel_i  in  DATA_WIDTH/8  byte selects
wbm_we_i  in  1  write enable
wbm_cyc_i  in  1  cycle
wbm_stb_i  in  1  strobe
wbm_ack_o  out  1  normal termination
wbm_err_o  out  1  error termination (unmapped address or timeout)
wbs_adr_o  out  32  address broadcast to all slaves
wbs_dat_o  out  DATA_WIDTH  write data broadcast
wbs_sel_o  out  DATA_WIDTH/8  byte selects broadcast
wbs_we_o  out  1  write enable broadcast
wbs_cyc_o  out  NUM_SLAVES  one-hot cycle per slave
wbs_stb_o  out  NUM_SLAVES  one-hot strobe per slave
wbs_dat_i  in  NUM_SLAVES*DATA_WIDTH  packed slave read data; slave k at [DW*k+DW-1:DW*k]
wbs_ack_i  in  NUM_SLAVES  per-slave ack
fault_o  out  1  sticky fault flag
fault_adr_o  out  32  address of the first faulting access since last clear
fault_tmo_o  out  1  1 = latched fault was a timeout; 0 = unmapped address
fault_clr_i  in  1  one-cycle pulse that clears fault_o

Behaviour:
- Reset values: all wbs_cyc_o and wbs_stb_o = 0; wbm_ack_o = 0, wbm_err_o = 0; fault_o = 0, fault_adr_o = 0, fault_tmo_o = 0; FSM in IDLE; counter = 0. Reset takes effect at the next edge, including mid-transaction; slaves see strobe dropped with no ack or err to the master.
- Broadcast signals are combinational pass-throughs: wbs_adr_o/dat_o/sel_o/we_o = master inputs.
- FSM states: IDLE, DECODE, ACTIVE, ERR.
- IDLE: when wbm_cyc_i & wbm_stb_i are both high, register wbm_adr_i and go to DECODE.
- DECODE: compute the match vector from the registered address. The lowest-index matching slave wins on overlap. Latch the one-hot select.
  - No match -> ERR.
  - Match -> ACTIVE; that slave's cyc and stb are asserted from this edge; counter cleared.
- ACTIVE:
  - wbm_ack_o = wbs_ack_i[sel] combinationally; wbm_dat_o = selected slave data.
  - On ack -> IDLE; slave strobe deasserted at the following edge.
  - No ack: counter increments. When counter == TIMEOUT-1 without ack -> ERR; slave cyc/stb deasserted.
  - Ack arriving in the same cycle the counter reaches TIMEOUT-1: ack wins; no fault.
- ERR: wbm_err_o = 1 for exactly one cycle, then IDLE. wbm_ack_o is never asserted together with wbm_err_o.
- Master abort: wbm_cyc_i or wbm_stb_i low in DECODE/ACTIVE -> IDLE next edge, slave strobes drop, no ack/err, no fault.
- Minimum latency: master stb to ack = 2 cycles plus slave latency. Back-to-back accesses re-enter DECODE each time.
- wbm_dat_o = 0 when not in ACTIVE.
- Fault register:
  - On entering ERR with fault_o = 0: set fault_o; latch the registered address into fault_adr_o; set fault_tmo_o (1 for timeout, 0 for unmapped).
  - Further faults while fault_o = 1 do not overwrite the latched values.
  - fault_clr_i clears fault_o. If fault_clr_i and a new fault occur in the same cycle, the new fault is latched and fault_o stays 1.
- Counter width is clog2(TIMEOUT+1). The counter saturates; it never wraps.

Test Plan:
- Read ROM: NUM_SLAVES=4, slave0 addr 0x00001000 mask 0xFFFFF000; slave acks 1 cycle after stb with 0xBEEF. Master reads 0x00001234 -> wbs_stb_o = 4'b0001, wbm_ack_o high for 1 cycle with wbm_dat_o = 0xBEEF, 3 cycles after master stb.
- Unmapped: write to 0x80000000 -> no wbs_stb_o bit ever high; wbm_err_o pulses 1 cycle; fault_o = 1, fault_adr_o = 0x80000000, fault_tmo_o = 0.
- Timeout: TIMEOUT=8, access slave2 at 0xF0000004, slave never acks -> wbs_stb_o[2] high exactly 8 cycles; then wbm_err_o pulses; fault_tmo_o = 1. A second fault does not change fault_adr_o. fault_clr_i -> fault_o = 0.
- Race: slave ack in the cycle the counter hits TIMEOUT-1 -> wbm_ack_o = 1, wbm_err_o stays 0, fault_o stays 0.
- Abort/reset: master drops stb mid-ACTIVE -> IDLE, no ack/err. Assert rst_i mid-ACTIVE -> all strobes 0 and fault_o = 0 at the next edge.
- Overlap priority: slaves 1 and 3 both match 0xF0000000 -> only wbs_stb_o[1] asserts.
